// File: rtl/alu_flags_seq.sv
// alu_flags_seq: registered ALU with status flags, accumulator and a shift-add multiplier.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     operand handshake; a (or acc), b and op captured on accept
//   a, b [WIDTH]            operands
//   op [3]                  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
//   use_acc                 use the accumulator in place of a
//   out_valid / out_ready   result handshake; result and flags hold while not taken
//   result [WIDTH]          registered result
//   carry, zero, negative, overflow  registered flags for result
//   sticky_ovf, clr_sticky  sticky overflow flag and its clear
//   acc [WIDTH]             accumulator, last loaded result
module alu_flags_seq #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             sticky_ovf,
  input  logic             clr_sticky,
  output logic [WIDTH-1:0] acc
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [2:0] OpMul = 3'b111;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;

  logic [WIDTH-1:0]     opa;
  logic                 accept;
  logic [WIDTH:0]       add_w;
  logic [WIDTH:0]       sub_w;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c;
  logic                 alu_v;
  logic [2*WIDTH-1:0]   mul_sum;
  logic                 mul_last;
  logic                 mul_hi_nz;
  logic                 load;
  logic [WIDTH-1:0]     load_res;
  logic                 load_c;
  logic                 load_v;

  assign in_ready = (state_q == StIdle) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign opa      = use_acc ? acc : a;

  assign add_w = {1'b0, opa} + {1'b0, b};
  // Top bit of the widened difference is the borrow (opa < b unsigned).
  assign sub_w = {1'b0, opa} - {1'b0, b};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      3'b000: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (opa[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != opa[WIDTH-1]);
      end
      3'b001: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (opa[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != opa[WIDTH-1]);
      end
      3'b010: alu_res = opa & b;
      3'b011: alu_res = opa | b;
      3'b100: alu_res = opa ^ b;
      3'b101: begin
        alu_res = {opa[WIDTH-2:0], 1'b0};
        alu_c   = opa[WIDTH-1];
      end
      3'b110: begin
        alu_res = {1'b0, opa[WIDTH-1:1]};
        alu_c   = opa[0];
      end
      default: ;
    endcase
  end

  // One multiplier bit per cycle; the final partial sum is the full product.
  assign mul_sum   = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last  = (cnt_q == CntW'(WIDTH - 1));
  assign mul_hi_nz = |mul_sum[2*WIDTH-1:WIDTH];

  always_comb begin
    load     = 1'b0;
    load_res = alu_res;
    load_c   = alu_c;
    load_v   = alu_v;
    if (state_q == StMul) begin
      load     = mul_last;
      load_res = mul_sum[WIDTH-1:0];
      load_c   = mul_hi_nz;
      load_v   = mul_hi_nz;
    end else begin
      load = accept && (op != OpMul);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      prod_q     <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      out_valid  <= 1'b0;
      result     <= '0;
      carry      <= 1'b0;
      zero       <= 1'b0;
      negative   <= 1'b0;
      overflow   <= 1'b0;
      sticky_ovf <= 1'b0;
      acc        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept && (op == OpMul)) begin
            state_q  <= StMul;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, opa};
            mplier_q <= b;
          end
        end
        StMul: begin
          prod_q   <= mul_sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CntW'(1);
          if (mul_last) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (load) begin
        out_valid <= 1'b1;
        result    <= load_res;
        carry     <= load_c;
        zero      <= (load_res == '0);
        negative  <= load_res[WIDTH-1];
        overflow  <= load_v;
        acc       <= load_res;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // An overflowing load beats a coincident clear.
      if (load && load_v) begin
        sticky_ovf <= 1'b1;
      end else if (clr_sticky) begin
        sticky_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_flags_seq.sv
// tb_alu_flags_seq: scoreboard bench for alu_flags_seq at WIDTH=5.
module tb_alu_flags_seq;

  localparam int unsigned W = 5;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         use_acc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         negative;
  logic         overflow;
  logic         sticky_ovf;
  logic         clr_sticky;
  logic [W-1:0] acc;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         n;
    logic         v;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_acc = 0;

  alu_flags_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op         (op),
    .use_acc    (use_acc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .carry      (carry),
    .zero       (zero),
    .negative   (negative),
    .overflow   (overflow),
    .sticky_ovf (sticky_ovf),
    .clr_sticky (clr_sticky),
    .acc        (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference arithmetic on plain integers, independent of bit-level structure.
  function automatic exp_t model(input logic [2:0] o, input int x, input int y);
    exp_t e;
    int s, sx, sy, ss;
    e.c = 1'b0;
    e.v = 1'b0;
    sx = (x >= 16) ? x - 32 : x;
    sy = (y >= 16) ? y - 32 : y;
    s  = 0;
    case (o)
      3'd0: begin s = x + y; e.c = (s >= 32); ss = sx + sy; e.v = (ss > 15) || (ss < -16); end
      3'd1: begin s = x - y + 32; e.c = (x < y); ss = sx - sy; e.v = (ss > 15) || (ss < -16); end
      3'd2: s = x & y;
      3'd3: s = x | y;
      3'd4: s = x ^ y;
      3'd5: begin s = x * 2; e.c = (x >= 16); end
      3'd6: begin s = x / 2; e.c = (x % 2) == 1; end
      default: begin s = x * y; e.c = (s >= 32); e.v = e.c; end
    endcase
    e.r = W'(s % 32);
    e.z = (e.r == 0);
    e.n = e.r[W-1];
    return e;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] o, input int av, input int bv, input logic ua);
    exp_t e;
    int   n;
    int   xa;
    xa = ua ? m_acc : av;
    e  = model(o, xa, bv);
    q.push_back(e);
    m_acc    = e.r;
    op       = o;
    a        = W'(av);
    b        = W'(bv);
    use_acc  = ua;
    in_valid = 1'b1;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 32'(n), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard: a result is delivered at the next edge when valid and ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        check("q_nonempty", 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("res", 32'(result), 32'(e.r));
          check("carry", 32'(carry), 32'(e.c));
          check("zero", 32'(zero), 32'(e.z));
          check("neg", 32'(negative), 32'(e.n));
          check("ovf", 32'(overflow), 32'(e.v));
        end
      end
    end
  end

  initial begin
    int n;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    op         = '0;
    use_acc    = 1'b0;
    out_ready  = 1'b1;
    clr_sticky = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_result", 32'(result), 0);
    check("rst_flags", 32'({carry, zero, negative, overflow}), 0);
    check("rst_sticky", 32'(sticky_ovf), 0);
    check("rst_acc", 32'(acc), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    #11;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(3'd0, 5, 3, 1'b0);
    check("lat1_valid", 32'(out_valid), 1);
    send(3'd0, 0, 0, 1'b0);
    send(3'd0, 20, 15, 1'b0);
    check("sticky_clean", 32'(sticky_ovf), 0);
    send(3'd0, 15, 1, 1'b0);
    check("sticky_set", 32'(sticky_ovf), 1);
    send(3'd0, 1, 1, 1'b0);
    send(3'd1, 3, 5, 1'b0);
    check("sticky_hold", 32'(sticky_ovf), 1);

    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    check("sticky_clr", 32'(sticky_ovf), 0);

    clr_sticky = 1'b1;
    send(3'd0, 15, 1, 1'b0);
    clr_sticky = 1'b0;
    check("sticky_set_wins", 32'(sticky_ovf), 1);

    send(3'd7, 6, 7, 1'b0);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("mul_busy_cycles", 32'(n), W);
    check("mul_valid", 32'(out_valid), 1);
    @(posedge clk);
    #1;
    send(3'd7, 3, 4, 1'b0);

    for (int i = 0; i < 10; i++) begin
      send(3'($urandom_range(0, 7)), $urandom_range(0, 31), $urandom_range(0, 31),
           1'($urandom_range(0, 1)));
    end
    // Let any trailing multiply finish and drain.
    repeat (W + 2) @(posedge clk);
    #1;

    out_ready = 1'b0;
    send(3'd0, 1, 2, 1'b0);
    fork
      send(3'd0, 4, 4, 1'b0);
      begin
        repeat (3) @(negedge clk);
        check("bp_result", 32'(result), 3);
        check("bp_valid", 32'(out_valid), 1);
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_acc", 32'(acc), 3);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    check("bp_new_acc", 32'(acc), 8);

    send(3'd0, 2, 3, 1'b0);
    send(3'd0, 0, 4, 1'b1);
    check("acc_chain", 32'(acc), 9);

    send(3'd7, 5, 5, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_acc = 0;
    check("mrst_valid", 32'(out_valid), 0);
    check("mrst_result", 32'(result), 0);
    check("mrst_flags", 32'({carry, zero, negative, overflow}), 0);
    check("mrst_sticky", 32'(sticky_ovf), 0);
    check("mrst_acc", 32'(acc), 0);
    #2;
    rst_n = 1'b1;
    repeat (W + 3) begin
      @(negedge clk);
      check("mrst_no_out", 32'(out_valid), 0);
    end
    check("mrst_acc_after", 32'(acc), 0);
    check("mrst_in_ready", 32'(in_ready), 1);
    check("q_empty", 32'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_flags_seq.md
# alu_flags_seq

Registered, parametrised ALU with status flags, an accumulator and a multi-cycle multiply, used by the vending-machine datapath for price/credit arithmetic. Operands enter through a valid/ready handshake. Results leave through a valid/ready handshake with a held output register. Supersedes the combinational 5-bit add/flag ALU: width is generic, logic/shift/multiply ops and signed overflow are added, and a sticky overflow flag is kept.

## Interface
- WIDTH, 5, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  block can accept this cycle
- a  in  WIDTH  operand A (unsigned bit vector)
- b  in  WIDTH  operand B
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
- use_acc  in  1  substitute accumulator for a
- out_valid  out  1  result register holds an undelivered result
- out_ready  in  1  consumer takes result this cycle
- result  out  WIDTH  registered result
- carry, zero, negative, overflow  out  1 each  registered flags for result
- sticky_ovf  out  1  set by any delivered result with overflow=1
- clr_sticky  in  1  clears sticky_ovf
- acc  out  WIDTH  accumulator (last loaded result)

## Operation
- Accept happens when in_valid && in_ready at a rising edge. a (or acc when use_acc=1), b and op are captured at that edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready). It is combinational from registered state and out_ready, and never depends on in_valid.
- FSM states:
  - IDLE: on accept of ops 000–110, compute and load the output register, stay in IDLE. On accept of MUL, go to MUL with cnt=0.
  - MUL: shift-add one bit of b per cycle. cnt increments each cycle. When cnt==WIDTH-1, load the output register and return to IDLE.
- Arithmetic, all modulo 2^WIDTH on result:
  - ADD: carry = bit WIDTH of a+b.
  - SUB: carry = borrow, i.e. 1 iff a<b unsigned.
  - ADD/SUB overflow = two's-complement signed overflow.
  - AND/OR/XOR: carry=0, overflow=0.
  - SHL: result = a<<1, carry = a[WIDTH-1], overflow=0.
  - SHR: logical shift, result = a>>1, carry = a[0], overflow=0.
  - MUL: result = low WIDTH bits of the unsigned product. carry = overflow = 1 iff the high WIDTH bits are nonzero.
- zero = (result==0). negative = result[WIDTH-1].
- On every output-register load, acc <= result and sticky_ovf |= overflow.
- clr_sticky clears sticky_ovf. If clr_sticky coincides with a load that has overflow=1, set wins.
- When out_valid && !out_ready, result, flags and out_valid hold stable.
- When out_ready && !out_valid, nothing happens.
- The output register clears out_valid on delivery unless it is reloaded in the same cycle.

## Timing
- Reset (async assert, sync release) sets state=IDLE, cnt=0, out_valid=0, result=0, all flags=0, sticky_ovf=0, acc=0. in_ready=1 while out_valid=0.
- Ops 000–110: accept at edge k → out_valid=1 with result after edge k (1-cycle latency).
- Back-to-back throughput is 1/cycle while out_ready=1.
- MUL: accept at edge k → out_valid after edge k+WIDTH. in_ready=0 for those WIDTH cycles.
- use_acc with back-to-back accepts sees the acc value loaded by the immediately preceding result (acc is updated at the same edge the result loads).
- Reset asserted mid-MUL aborts the multiply: no result is produced and acc is not updated.

## Test plan
- WIDTH=5, ADD a=5 b=3 → next cycle result=8, carry=0, zero=0, negative=0, overflow=0.
- ADD 0+0 → zero=1, then ADD 20+15 → result=3, carry=1. ADD 15+1 → result=16, negative=1, overflow=1, sticky_ovf=1.
- Sticky flag: sticky_ovf stays 1 through later clean ADDs. clr_sticky=1 alone → 0. clr_sticky coincident with an overflowing load → stays 1.
- MUL 6×7 → in_ready=0 for 5 cycles, then result=10, carry=1, overflow=1. MUL 3×4 → result=12, carry=0.
- Backpressure: out_ready=0 with a result pending → result and flags hold, in_ready=0, no accept. Raising out_ready → delivered and a new accept in the same cycle.
- Accumulate and reset: ADD a=2 b=3, then ADD use_acc=1 b=4 → result=9. Start MUL, assert rst_n=0 after 2 cycles → all outputs 0, acc=0, no out_valid.
